// File: rtl/ii_rect_sum.sv
// Rectangle sum over an integral image: fetches up to four corner entries
// (D - B - C + A) and returns the pixel sum with a valid/ready handshake.
module ii_rect_sum #(
  parameter int II_WIDTH  = 160,
  parameter int II_HEIGHT = 120
) (
  input  logic        ov7670_pclk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_x,
  input  logic [7:0]  req_y,
  input  logic [7:0]  req_w,
  input  logic [7:0]  req_h,
  output logic        ii_rd_en,
  output logic [14:0] ii_rd_address,
  input  logic [31:0] ii_rd_data,
  output logic        sum_valid,
  output logic [19:0] sum,
  output logic        sum_err,
  input  logic        sum_ready
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, RD2, RD3, WAIT, OUT} state_t;

  state_t             state_r, state_s;
  logic [7:0]         x_r, y_r, w_r, h_r;
  logic signed [20:0] acc_r, acc_s, term_s;
  logic               pend_r, pend_sub_r;
  logic               rd_sub_r;
  logic               accept_s, req_bad_s;
  logic [8:0]         x_end_s, y_end_s, x2_s, y2_s;
  logic [7:0]         g_x_s, g_y_s, g_w_s, g_h_s;
  logic               rd_s, sub_s;
  logic [7:0]         row_s, col_s;
  logic               unused_data_s;

  assign req_ready     = (state_r == IDLE);
  assign accept_s      = req_valid && (state_r == IDLE);
  assign unused_data_s = ^ii_rd_data[31:20];

  assign x_end_s   = {1'b0, req_x} + {1'b0, req_w};
  assign y_end_s   = {1'b0, req_y} + {1'b0, req_h};
  assign req_bad_s = (req_w == 8'd0) || (req_h == 8'd0) ||
                     (x_end_s > 9'(II_WIDTH)) || (y_end_s > 9'(II_HEIGHT));

  // Corner geometry comes straight from the request on the accept edge.
  assign g_x_s = accept_s ? req_x : x_r;
  assign g_y_s = accept_s ? req_y : y_r;
  assign g_w_s = accept_s ? req_w : w_r;
  assign g_h_s = accept_s ? req_h : h_r;
  assign x2_s  = {1'b0, g_x_s} + {1'b0, g_w_s} - 9'd1;
  assign y2_s  = {1'b0, g_y_s} + {1'b0, g_h_s} - 9'd1;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = req_bad_s ? OUT : RD0;
        end else begin
          state_s = IDLE;
        end
      end
      RD0:  state_s = RD1;
      RD1:  state_s = RD2;
      RD2:  state_s = RD3;
      RD3:  state_s = WAIT;
      WAIT: state_s = OUT;
      OUT: begin
        if (sum_ready) begin
          state_s = IDLE;
        end else begin
          state_s = OUT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Corner selection for the read issued while in the upcoming state.
  always_comb begin
    rd_s  = 1'b0;
    sub_s = 1'b0;
    row_s = 8'd0;
    col_s = 8'd0;
    case (state_s)
      RD0: begin
        rd_s  = 1'b1;
        row_s = y2_s[7:0];
        col_s = x2_s[7:0];
      end
      RD1: begin
        rd_s  = (g_y_s != 8'd0);
        sub_s = 1'b1;
        row_s = g_y_s - 8'd1;
        col_s = x2_s[7:0];
      end
      RD2: begin
        rd_s  = (g_x_s != 8'd0);
        sub_s = 1'b1;
        row_s = y2_s[7:0];
        col_s = g_x_s - 8'd1;
      end
      RD3: begin
        rd_s  = (g_x_s != 8'd0) && (g_y_s != 8'd0);
        row_s = g_y_s - 8'd1;
        col_s = g_x_s - 8'd1;
      end
      default: begin
        rd_s = 1'b0;
      end
    endcase
  end

  // RAM data returns two edges after the strobe is registered.
  always_comb begin
    term_s = $signed({1'b0, ii_rd_data[19:0]});
    if (pend_r) begin
      acc_s = pend_sub_r ? (acc_r - term_s) : (acc_r + term_s);
    end else begin
      acc_s = acc_r;
    end
  end

  // State, request capture, read port, accumulator and result registers.
  always_ff @(posedge ov7670_pclk) begin
    if (rst) begin
      state_r       <= IDLE;
      x_r           <= 8'd0;
      y_r           <= 8'd0;
      w_r           <= 8'd0;
      h_r           <= 8'd0;
      acc_r         <= 21'sd0;
      ii_rd_en      <= 1'b0;
      ii_rd_address <= 15'd0;
      rd_sub_r      <= 1'b0;
      pend_r        <= 1'b0;
      pend_sub_r    <= 1'b0;
      sum_valid     <= 1'b0;
      sum           <= 20'd0;
      sum_err       <= 1'b0;
    end else begin
      state_r    <= state_s;
      ii_rd_en   <= rd_s;
      rd_sub_r   <= sub_s;
      pend_r     <= ii_rd_en;
      pend_sub_r <= rd_sub_r;
      if (rd_s) begin
        ii_rd_address <= {7'd0, row_s} * 15'(II_WIDTH) + {7'd0, col_s};
      end else begin
        ii_rd_address <= ii_rd_address;
      end
      if (accept_s) begin
        x_r   <= req_x;
        y_r   <= req_y;
        w_r   <= req_w;
        h_r   <= req_h;
        acc_r <= 21'sd0;
      end else begin
        acc_r <= acc_s;
      end
      if ((state_s == OUT) && (state_r != OUT)) begin
        sum_valid <= 1'b1;
        sum_err   <= (state_r == IDLE);
        sum       <= (state_r == IDLE) ? 20'd0 : acc_s[19:0];
      end else if ((state_r == OUT) && sum_ready) begin
        sum_valid <= 1'b0;
      end else begin
        sum_valid <= sum_valid;
      end
    end
  end

endmodule

// File: tb/tb_ii_rect_sum.sv
// Scoreboard bench for ii_rect_sum against an all-ones integral image.
module tb_ii_rect_sum;

  logic        ov7670_pclk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_x = 8'd0, req_y = 8'd0, req_w = 8'd0, req_h = 8'd0;
  logic        ii_rd_en;
  logic [14:0] ii_rd_address;
  logic [31:0] ii_rd_data = 32'd0;
  logic        sum_valid;
  logic [19:0] sum;
  logic        sum_err;
  logic        sum_ready = 1'b1;

  ii_rect_sum #(.II_WIDTH(160), .II_HEIGHT(120)) dut (
    .ov7670_pclk(ov7670_pclk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .ii_rd_en(ii_rd_en), .ii_rd_address(ii_rd_address), .ii_rd_data(ii_rd_data),
    .sum_valid(sum_valid), .sum(sum), .sum_err(sum_err), .sum_ready(sum_ready)
  );

  always #5 ov7670_pclk = ~ov7670_pclk;

  typedef struct {
    logic [19:0] s;
    logic        e;
    int          lat;
    int          acyc;
  } res_t;

  res_t res_q[$];
  int   addr_q[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   hold_req = 0;

  always @(posedge ov7670_pclk) cyc <= cyc + 1;

  // All-ones image; upper data bits carry junk the DUT must ignore.
  always @(posedge ov7670_pclk) begin
    if (ii_rd_en) begin
      ii_rd_data <= {12'hFA5, 20'((int'(ii_rd_address) / 160 + 1) * (int'(ii_rd_address) % 160 + 1))};
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read-address monitor.
  initial begin
    forever begin
      @(negedge ov7670_pclk);
      if (ii_rd_en) begin
        if (addr_q.size() == 0) chk("unexpected_read", int'(ii_rd_address), -1);
        else chk("rd_addr", int'(ii_rd_address), addr_q.pop_front());
      end
    end
  end

  // Result monitor: latency, value, hold stability, consumption.
  initial begin
    res_t cur;
    bit   active = 1'b0;
    bit   consumed = 1'b0;
    cur = '{20'd0, 1'b0, 0, 0};
    forever begin
      @(negedge ov7670_pclk);
      if (consumed) begin
        chk("valid_drop", int'(sum_valid), 0);
        chk("ready_back", int'(req_ready), 1);
        consumed = 1'b0;
      end
      if (active) chk("valid_hold", int'(sum_valid), 1);
      if (sum_valid && !active) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", int'(sum_valid), 0);
        end else begin
          cur = res_q.pop_front();
          active = 1'b1;
          chk("latency", cyc - cur.acyc + 1, cur.lat);
        end
      end
      if (active) begin
        chk("sum", int'(sum), int'(cur.s));
        chk("sum_err", int'(sum_err), int'(cur.e));
        if (hold_req > 0) begin
          sum_ready = 1'b0;
          hold_req--;
        end else begin
          sum_ready = 1'b1;
          active = 1'b0;
          consumed = 1'b1;
        end
      end else begin
        sum_ready = 1'b1;
      end
    end
  end

  task automatic send(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w,
                      input logic [7:0] h, input int a[4], input int na,
                      input logic [19:0] s, input logic e, input bit want_res);
    int t = 0;
    @(negedge ov7670_pclk);
    req_x = x; req_y = y; req_w = w; req_h = h;
    req_valid = 1'b1;
    while (!req_ready && t < 100) begin
      @(negedge ov7670_pclk);
      t++;
    end
    if (t >= 100) chk("req_ready_timeout", int'(req_ready), 1);
    for (int i = 0; i < na; i++) addr_q.push_back(a[i]);
    @(posedge ov7670_pclk);
    #1;
    if (want_res) res_q.push_back('{s, e, (e ? 1 : 6), cyc});
    req_valid = 1'b0;
  endtask

  initial begin
    int t;
    repeat (3) @(posedge ov7670_pclk);
    @(negedge ov7670_pclk);
    chk("rst_sum_valid", int'(sum_valid), 0);
    chk("rst_sum", int'(sum), 0);
    chk("rst_sum_err", int'(sum_err), 0);
    chk("rst_rd_en", int'(ii_rd_en), 0);
    chk("rst_rd_addr", int'(ii_rd_address), 0);
    rst = 1'b0;
    @(negedge ov7670_pclk);
    chk("ready_after_rst", int'(req_ready), 1);

    send(8'd10, 8'd20, 8'd5, 8'd4, '{3694, 3054, 3689, 3049}, 4, 20'd20, 1'b0, 1'b1);
    send(8'd0, 8'd0, 8'd160, 8'd120, '{19199, 0, 0, 0}, 1, 20'd19200, 1'b0, 1'b1);
    send(8'd0, 8'd5, 8'd3, 8'd2, '{962, 642, 0, 0}, 2, 20'd6, 1'b0, 1'b1);
    send(8'd150, 8'd0, 8'd11, 8'd1, '{0, 0, 0, 0}, 0, 20'd0, 1'b1, 1'b1);
    send(8'd5, 8'd5, 8'd0, 8'd3, '{0, 0, 0, 0}, 0, 20'd0, 1'b1, 1'b1);
    send(8'd0, 8'd100, 8'd1, 8'd21, '{0, 0, 0, 0}, 0, 20'd0, 1'b1, 1'b1);
    send(8'd159, 8'd119, 8'd1, 8'd1, '{19199, 19039, 19198, 19038}, 4, 20'd1, 1'b0, 1'b1);

    hold_req = 3;
    send(8'd3, 8'd2, 8'd4, 8'd3, '{646, 166, 642, 162}, 4, 20'd12, 1'b0, 1'b1);

    // Reset lands on the edge that leaves RD2; only D, B and C get issued.
    send(8'd10, 8'd20, 8'd5, 8'd4, '{3694, 3054, 3689, 0}, 3, 20'd0, 1'b0, 1'b0);
    @(negedge ov7670_pclk);
    @(negedge ov7670_pclk);
    @(negedge ov7670_pclk);
    rst = 1'b1;
    @(negedge ov7670_pclk);
    chk("rst_mid_rd_en", int'(ii_rd_en), 0);
    chk("rst_mid_valid", int'(sum_valid), 0);
    rst = 1'b0;

    send(8'd1, 8'd1, 8'd1, 8'd1, '{161, 1, 160, 0}, 4, 20'd1, 1'b0, 1'b1);

    t = 0;
    while ((res_q.size() != 0 || addr_q.size() != 0 || sum_valid) && t < 200) begin
      @(negedge ov7670_pclk);
      t++;
    end
    repeat (4) @(negedge ov7670_pclk);
    chk("results_left", res_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
